// File: rtl/sample_quad_iter.sv
// Sample iterator: walks a triangle's bounding box and emits 4-lane sample quads.
// Optional ITER_PERF_CNT_EN adds a saturating 32-bit emitted-sample counter.
module sample_quad_iter #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS],
  input  logic        [SIGFIG-1:0] color_R13U [COLORS],
  input  logic signed [SIGFIG-1:0] box_R13S [2][2],
  input  logic                     validTri_R13H,
  input  logic [3:0]               subSample_RnnnnU,
  output logic                     halt_RnnnnL,
  output logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS],
  output logic        [SIGFIG-1:0] color_R14U [COLORS],
  output logic signed [SIGFIG-1:0] sample_R14S [2][4],
  output logic [3:0]               validSamp_R14H
`ifdef ITER_PERF_CNT_EN
  ,
  output logic [31:0]              sampCnt_RnnnnU
`endif
);

  localparam int W = SIGFIG + 1;

  typedef enum logic {
    WAIT,
    TEST
  } state_t;

  state_t state_q, state_d;

  logic signed [W-1:0] step;
  logic signed [W-1:0] x_q, y_q;
  logic signed [W-1:0] ll_x_q, ur_x_q, ur_y_q;
  logic signed [W-1:0] qx, qy, qur_x;
  logic signed [W-1:0] nx4, ny;
  logic signed [W-1:0] lane_x [4];
  logic [3:0]          lane_v;
  logic                load, adv;

  function automatic logic signed [W-1:0] sx(
    input logic signed [SIGFIG-1:0] v
  );
    return {v[SIGFIG-1], v};
  endfunction

  assign halt_RnnnnL = (state_q == WAIT);

  // Subsample pitch from the one-hot MSAA select.
  always_comb begin
    step = W'(1) << RADIX;
    unique case (1'b1)
      subSample_RnnnnU[3]: step = W'(1) << RADIX;
      subSample_RnnnnU[2]: step = W'(1) << (RADIX - 1);
      subSample_RnnnnU[1]: step = W'(1) << (RADIX - 2);
      subSample_RnnnnU[0]: step = W'(1) << (RADIX - 3);
      default:             step = W'(1) << RADIX;
    endcase
  end

  // Next state and the quad to register for the coming cycle.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    adv     = 1'b0;
    nx4     = x_q + (step <<< 2);
    ny      = y_q + step;
    qx      = x_q;
    qy      = y_q;
    qur_x   = ur_x_q;
    unique case (state_q)
      WAIT: begin
        if (validTri_R13H) begin
          load    = 1'b1;
          state_d = TEST;
          qx      = sx(box_R13S[0][0]);
          qy      = sx(box_R13S[0][1]);
          qur_x   = sx(box_R13S[1][0]);
        end
      end
      TEST: begin
        if (nx4 <= ur_x_q) begin
          adv = 1'b1;
          qx  = nx4;
        end else if (ny <= ur_y_q) begin
          adv = 1'b1;
          qx  = ll_x_q;
          qy  = ny;
        end else begin
          state_d = WAIT;
        end
      end
      default: state_d = WAIT;
    endcase
    lane_x[0] = qx;
    lane_x[1] = qx + step;
    lane_x[2] = qx + (step <<< 1);
    lane_x[3] = lane_x[2] + step;
    for (int k = 0; k < 4; k++) begin
      lane_v[k] = (lane_x[k] <= qur_x);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Walk position, latched triangle and registered quad outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q            <= '0;
      y_q            <= '0;
      ll_x_q         <= '0;
      ur_x_q         <= '0;
      ur_y_q         <= '0;
      validSamp_R14H <= '0;
      for (int v = 0; v < VERTS; v++) begin
        for (int a = 0; a < AXIS; a++) begin
          tri_R14S[v][a] <= '0;
        end
      end
      for (int c = 0; c < COLORS; c++) begin
        color_R14U[c] <= '0;
      end
      for (int k = 0; k < 4; k++) begin
        sample_R14S[0][k] <= '0;
        sample_R14S[1][k] <= '0;
      end
    end else begin
      if (load) begin
        ll_x_q   <= sx(box_R13S[0][0]);
        ur_x_q   <= sx(box_R13S[1][0]);
        ur_y_q   <= sx(box_R13S[1][1]);
        tri_R14S <= tri_R13S;
        color_R14U <= color_R13U;
      end
      if (load || adv) begin
        x_q            <= qx;
        y_q            <= qy;
        validSamp_R14H <= lane_v;
        for (int k = 0; k < 4; k++) begin
          sample_R14S[0][k] <= lane_x[k][SIGFIG-1:0];
          sample_R14S[1][k] <= qy[SIGFIG-1:0];
        end
      end else begin
        validSamp_R14H <= '0;
      end
    end
  end

  // The pitch select must be one-hot whenever it steers the walk.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == TEST || validTri_R13H)) begin
      assert ($onehot(subSample_RnnnnU));
    end
  end

`ifdef ITER_PERF_CNT_EN
  logic [32:0] cnt_sum;

  assign cnt_sum = {1'b0, sampCnt_RnnnnU}
                 + 33'($countones(validSamp_R14H));

  // Saturating count of samples emitted.
  always_ff @(posedge clk) begin
    if (rst) begin
      sampCnt_RnnnnU <= '0;
    end else begin
      sampCnt_RnnnnU <= cnt_sum[32] ? '1 : cnt_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_sample_quad_iter.sv
// Bench for sample_quad_iter: directed boxes, scoreboarded quads.
// Also checks the sample counter when ITER_PERF_CNT_EN is defined.
module tb_sample_quad_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [23:0] tri_in [3][3];
  logic [23:0] color_in [3];
  logic signed [23:0] box_in [2][2];
  logic valid_in = 1'b0;
  logic [3:0] sub = 4'b1000;
  logic halt;
  logic signed [23:0] tri_out [3][3];
  logic [23:0] color_out [3];
  logic signed [23:0] samp_out [2][4];
  logic [3:0] vld_out;
`ifdef ITER_PERF_CNT_EN
  logic [31:0] samp_cnt;
`endif

  sample_quad_iter dut (
    .clk(clk),
    .rst(rst),
    .tri_R13S(tri_in),
    .color_R13U(color_in),
    .box_R13S(box_in),
    .validTri_R13H(valid_in),
    .subSample_RnnnnU(sub),
    .halt_RnnnnL(halt),
    .tri_R14S(tri_out),
    .color_R14U(color_out),
    .sample_R14S(samp_out),
    .validSamp_R14H(vld_out)
`ifdef ITER_PERF_CNT_EN
    ,
    .sampCnt_RnnnnU(samp_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][31:0] x;
    logic [31:0]      y;
    logic [3:0]       v;
    logic [31:0]      tag;
  } quad_t;

  quad_t sb[$];
  int checks = 0;
  int passed = 0;
  int exp_cnt = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) passed++;
    else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int step_of(input logic [3:0] ss);
    if (ss[3]) return 1024;
    if (ss[2]) return 512;
    if (ss[1]) return 256;
    return 128;
  endfunction

  task automatic push_box(input int llx, input int lly,
                          input int urx, input int ury,
                          input int step, input int tag,
                          input int maxq);
    quad_t q;
    int n;
    n = 0;
    for (int y = lly; y <= ury; y += step) begin
      for (int x = llx; x <= urx; x += 4 * step) begin
        for (int k = 0; k < 4; k++) begin
          q.x[k] = 32'(x + k * step);
          q.v[k] = (x + k * step <= urx);
        end
        q.y   = 32'(y);
        q.tag = 32'(tag);
        if (n < maxq) sb.push_back(q);
        n++;
      end
    end
  endtask

  task automatic send(input int llx, input int lly,
                      input int urx, input int ury,
                      input logic [3:0] ss, input int tag,
                      input int maxq);
    int n;
    sub = ss;
    for (int v = 0; v < 3; v++) begin
      for (int a = 0; a < 3; a++) begin
        tri_in[v][a] = 24'(tag * 16 + v * 4 + a);
      end
    end
    for (int c = 0; c < 3; c++) begin
      color_in[c] = 24'(tag * 100 + c);
    end
    box_in[0][0] = 24'(llx);
    box_in[0][1] = 24'(lly);
    box_in[1][0] = 24'(urx);
    box_in[1][1] = 24'(ury);
    valid_in = 1'b1;
    push_box(llx, lly, urx, ury, step_of(ss), tag, maxq);
    n = 0;
    while (!halt && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 64'(n < 100), 64'd1);
    @(negedge clk);
    valid_in = 1'b0;
    chk("first_quad_latency", 64'(vld_out[0]), 64'd1);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || !halt) && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk(tag, 64'(sb.size()), 64'd0);
`ifdef ITER_PERF_CNT_EN
    chk("samp_cnt", 64'(samp_cnt), 64'(exp_cnt));
`endif
  endtask

  // Pops one expected quad per emitted quad and compares every lane.
  always @(negedge clk) begin
    quad_t q;
    if (vld_out != 4'b0) begin
      if (sb.size() == 0) begin
        chk("unexpected_quad", 64'(vld_out), 64'd0);
      end else begin
        q = sb.pop_front();
        exp_cnt += $countones(q.v);
        chk("valid", 64'(vld_out), 64'(q.v));
        for (int k = 0; k < 4; k++) begin
          chk("lane_x", {40'b0, samp_out[0][k]}, {40'b0, q.x[k][23:0]});
          chk("lane_y", {40'b0, samp_out[1][k]}, {40'b0, q.y[23:0]});
        end
        chk("tri00", {40'b0, tri_out[0][0]}, 64'(24'(q.tag * 16)));
        chk("tri22", {40'b0, tri_out[2][2]}, 64'(24'(q.tag * 16 + 10)));
        chk("color2", {40'b0, color_out[2]}, 64'(24'(q.tag * 100 + 2)));
      end
    end
  end

  initial begin
    for (int v = 0; v < 3; v++) begin
      for (int a = 0; a < 3; a++) tri_in[v][a] = '0;
    end
    for (int c = 0; c < 3; c++) color_in[c] = '0;
    for (int i = 0; i < 2; i++) begin
      box_in[i][0] = '0;
      box_in[i][1] = '0;
    end

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_halt", 64'(halt), 64'd1);
    chk("rst_valid", 64'(vld_out), 64'd0);
    chk("rst_tri", {40'b0, tri_out[1][1]}, 64'd0);
    chk("rst_color", {40'b0, color_out[0]}, 64'd0);
    chk("rst_samp_x", {40'b0, samp_out[0][3]}, 64'd0);
    chk("rst_samp_y", {40'b0, samp_out[1][0]}, 64'd0);
`ifdef ITER_PERF_CNT_EN
    chk("rst_cnt", 64'(samp_cnt), 64'd0);
`endif
    rst = 1'b0;

    send(0, 0, 3072, 1024, 4'b1000, 1, 99);
    @(negedge clk);
    chk("halt_t2", 64'(halt), 64'd0);
    @(negedge clk);
    chk("halt_t3", 64'(halt), 64'd1);
    drain("drain_2row");

    send(0, 0, 4096, 0, 4'b1000, 2, 99);
    drain("drain_wide");

    send(2048, 2048, 2048, 2048, 4'b0100, 3, 99);
    drain("drain_degen");

    send(-512, -256, 0, 0, 4'b0010, 4, 99);
    drain("drain_neg");

    send(0, 0, 1024, 0, 4'b0001, 5, 99);
    drain("drain_msaa64");

    send(0, 0, 1024, 1024, 4'b1000, 6, 99);
    send(1024, 0, 2048, 0, 4'b1000, 7, 99);
    drain("drain_b2b");

    send(0, 0, 3072, 3072, 4'b1000, 8, 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    chk("midrst_valid", 64'(vld_out), 64'd0);
    chk("midrst_halt", 64'(halt), 64'd1);
    chk("midrst_sb", 64'(sb.size()), 64'd0);
`ifdef ITER_PERF_CNT_EN
    chk("midrst_cnt", 64'(samp_cnt), 64'd0);
`endif
    @(negedge clk);
    chk("midrst_idle", 64'(vld_out), 64'd0);

    send(0, 0, 0, 0, 4'b1000, 9, 99);
    drain("drain_after_rst");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
